// File: rtl/vend_kiosk_scheduler.sv
// vend_kiosk_scheduler: round-robin scheduler that shares one dispense engine
// among NREQ kiosks. It checks the product code, stock and credit, runs the
// engine handshake, and returns status and change to the granted kiosk. It also
// owns the per-product stock counters, which are refilled through a restock port.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_i                    per-kiosk request level, held until ack
//   req_prod_i, req_credit_i per-kiosk product code (2b) and credit (CW b)
//   ack_o, ack_status_o,     one-cycle one-hot completion with status
//   ack_change_o             (00 vend, 01 credit, 10 sold out, 11 invalid/timeout)
//                            and change; these three are decoded from state
//   eng_valid_o, eng_prod_o  registered dispense request to the engine
//   eng_ready_i, eng_done_i  engine accept / engine finished
//   restock_i, restock_prod_i, restock_qty_i  stock refill strobe
//   stock1_o, stock2_o       current stock counts
//   busy_o                   high whenever the FSM is not idle
module vend_kiosk_scheduler #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned CW         = 5,
  parameter int unsigned PRICE1     = 15,
  parameter int unsigned PRICE2     = 20,
  parameter int unsigned STOCK_INIT = 3,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_i,
  input  logic [2*NREQ-1:0]    req_prod_i,
  input  logic [CW*NREQ-1:0]   req_credit_i,
  output logic [NREQ-1:0]      ack_o,
  output logic [1:0]           ack_status_o,
  output logic [CW-1:0]        ack_change_o,
  output logic                 eng_valid_o,
  output logic [1:0]           eng_prod_o,
  input  logic                 eng_ready_i,
  input  logic                 eng_done_i,
  input  logic                 restock_i,
  input  logic [1:0]           restock_prod_i,
  input  logic [1:0]           restock_qty_i,
  output logic [1:0]           stock1_o,
  output logic [1:0]           stock2_o,
  output logic                 busy_o
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_CREDIT = 2'b01;
  localparam logic [1:0] ST_SOLD   = 2'b10;
  localparam logic [1:0] ST_INV    = 2'b11;
  localparam logic [1:0] STOCK_RST = (STOCK_INIT > 3) ? 2'd3 : 2'(STOCK_INIT);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q, idx_q;
  logic [1:0]      prod_q, status_q;
  logic [CW-1:0]   credit_q, change_q;
  logic [TW-1:0]   tmo_q;
  logic            eng_valid_q, busy_q;
  logic [1:0]      eng_prod_q;
  logic [1:0]      stock1_q, stock2_q;

  // Unpack the flat per-kiosk request buses
  logic [1:0]      prod_arr   [NREQ];
  logic [CW-1:0]   credit_arr [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign prod_arr[g]   = req_prod_i[2*g +: 2];
    assign credit_arr[g] = req_credit_i[CW*g +: CW];
  end

  // Round-robin pick: first set request at or after the pointer, wrapping
  logic            gnt_found_d;
  logic [IW-1:0]   gnt_idx_d;
  always_comb begin
    int unsigned cand;
    logic [IW-1:0] cand_idx;
    gnt_found_d = 1'b0;
    gnt_idx_d   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IW'(cand);
      if (!gnt_found_d && req_i[cand_idx]) begin
        gnt_found_d = 1'b1;
        gnt_idx_d   = cand_idx;
      end
    end
  end

  // Price and stock of the latched product
  logic [CW-1:0]   price_d;
  logic [1:0]      cur_stock_d;
  assign price_d     = (prod_q == 2'd2) ? CW'(PRICE2) : CW'(PRICE1);
  assign cur_stock_d = (prod_q == 2'd2) ? stock2_q : stock1_q;

  // Stock update: restock and handshake decrement may land on the same edge
  function automatic logic [1:0] next_stock(input logic [1:0] cur, input logic dec,
                                            input logic add, input logic [1:0] qty);
    logic [2:0] sum;
    sum = {1'b0, cur} + (add ? {1'b0, qty} : 3'd0) - {2'b00, dec};
    return (sum > 3'd3) ? 2'd3 : sum[1:0];
  endfunction

  logic            handshake_d;
  logic [1:0]      stock1_d, stock2_d;
  assign handshake_d = (state_q == S_ISSUE) && eng_ready_i;
  assign stock1_d = next_stock(stock1_q, handshake_d && (prod_q == 2'd1),
                               restock_i && (restock_prod_i == 2'd1), restock_qty_i);
  assign stock2_d = next_stock(stock2_q, handshake_d && (prod_q == 2'd2),
                               restock_i && (restock_prod_i == 2'd2), restock_qty_i);

  // Scheduler FSM with registered engine/busy outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      prod_q      <= '0;
      credit_q    <= '0;
      status_q    <= ST_OK;
      change_q    <= '0;
      tmo_q       <= '0;
      eng_valid_q <= 1'b0;
      eng_prod_q  <= '0;
      busy_q      <= 1'b0;
      stock1_q    <= STOCK_RST;
      stock2_q    <= STOCK_RST;
    end else begin
      stock1_q <= stock1_d;
      stock2_q <= stock2_d;
      unique case (state_q)
        S_IDLE: begin
          if (gnt_found_d) begin
            idx_q    <= gnt_idx_d;
            prod_q   <= prod_arr[gnt_idx_d];
            credit_q <= credit_arr[gnt_idx_d];
            busy_q   <= 1'b1;
            state_q  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (prod_q == 2'd0 || prod_q == 2'd3) begin
            status_q <= ST_INV;
            change_q <= credit_q;
            state_q  <= S_RESP;
          end else if (cur_stock_d == 2'd0) begin
            status_q <= ST_SOLD;
            change_q <= credit_q;
            state_q  <= S_RESP;
          end else if (credit_q < price_d) begin
            status_q <= ST_CREDIT;
            change_q <= credit_q;
            state_q  <= S_RESP;
          end else begin
            status_q    <= ST_OK;
            change_q    <= credit_q - price_d;
            eng_valid_q <= 1'b1;
            eng_prod_q  <= prod_q;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (eng_ready_i) begin
            eng_valid_q <= 1'b0;
            eng_prod_q  <= '0;
            tmo_q       <= '0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (eng_done_i) begin
            status_q <= ST_OK;
            state_q  <= S_RESP;
          end else begin
            tmo_q <= tmo_q + TW'(1);
            // Stock is not returned on timeout: the engine may have dispensed
            if (tmo_q == TW'(TIMEOUT - 1)) begin
              status_q <= ST_INV;
              change_q <= credit_q;
              state_q  <= S_RESP;
            end
          end
        end
        S_RESP: begin
          ptr_q   <= (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Completion is decoded from RESP so the kiosk sees it in that very cycle
  always_comb begin
    ack_o        = '0;
    ack_status_o = 2'b00;
    ack_change_o = '0;
    if (state_q == S_RESP) begin
      ack_o[idx_q] = 1'b1;
      ack_status_o = status_q;
      ack_change_o = change_q;
    end
  end

  assign eng_valid_o = eng_valid_q;
  assign eng_prod_o  = eng_prod_q;
  assign busy_o      = busy_q;
  assign stock1_o    = stock1_q;
  assign stock2_o    = stock2_q;

endmodule

// File: doc/vend_kiosk_scheduler.md
Name: vend_kiosk_scheduler

Overview:
- Shares one vending dispense engine among NREQ customer kiosks.
- Each kiosk presents a completed transaction (product code plus accumulated credit in 5/10 coin units).
- Round-robin arbitration; checks price and stock, issues the dispense to the engine, and returns status and change to the granted kiosk.
- Owns the per-product stock counters, which are restocked through a side port.

Parameters:
- NREQ, 4, number of kiosks (2..8).
- CW, 5, credit and change width.
- PRICE1, 15, price of product 1.
- PRICE2, 20, price of product 2.
- STOCK_INIT, 3, reset stock per product (saturates at 3).
- TIMEOUT, 15, maximum cycles in WAIT before abort.

Ports:
- clk, in, 1, clock; all logic on the rising edge.
- rst, in, 1, reset: asynchronous, active-low.
- req, in, NREQ, per-kiosk request level; held until ack.
- req_prod, in, 2*NREQ, product code per kiosk: 1 or 2 valid, 0 or 3 invalid.
- req_credit, in, CW*NREQ, credit per kiosk.
- ack, out, NREQ, one-cycle one-hot completion pulse.
- ack_status, out, 2, result: 00 vended, 01 insufficient credit, 10 sold out, 11 invalid/timeout. Valid with ack.
- ack_change, out, CW, change/refund; valid with ack.
- eng_valid, out, 1, dispense request to the engine.
- eng_prod, out, 2, product to dispense.
- eng_ready, in, 1, engine accepts the request.
- eng_done, in, 1, engine finished dispensing.
- restock, in, 1, restock strobe.
- restock_prod, in, 2, product to restock.
- restock_qty, in, 2, quantity to add.
- stock1, out, 2, product 1 stock.
- stock2, out, 2, product 2 stock.
- busy, out, 1, high whenever state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; ack=0, ack_status=00, ack_change=0.
  - eng_valid=0, eng_prod=0, busy=0.
  - stock1=stock2=STOCK_INIT; rr pointer=0; timeout counter=0.
  - Reset mid-transaction abandons it with no ack; eng_valid drops immediately.
- FSM states: IDLE, CHECK, ISSUE, WAIT, RESP.
- IDLE: if any req is set, grant the first set bit starting at the pointer (wrapping). Latch idx, prod and credit, then go to CHECK.
- CHECK (one cycle), priority order:
  - prod invalid -> status 11, change=credit.
  - stock of prod = 0 -> status 10, change=credit.
  - credit < price -> status 01, change=credit.
  - Each of the above goes to RESP.
  - Otherwise change=credit-price and go to ISSUE. Subtraction is done at CW bits and never underflows.
- ISSUE:
  - eng_valid=1 and eng_prod=prod, held stable until eng_ready=1 is sampled.
  - On that edge, decrement that product's stock, clear the timeout counter, and go to WAIT.
  - The engine may hold eng_ready high permanently; the handshake completes in the first ISSUE cycle.
- WAIT:
  - eng_valid=0.
  - eng_done=1 -> status 00, go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT without eng_done: status 11, change=full credit, go to RESP. Stock stays decremented on timeout.
- RESP:
  - ack[idx]=1 for exactly one cycle, with ack_status and ack_change driven in the same cycle.
  - pointer=(idx+1) mod NREQ; go to IDLE.
- Kiosk protocol:
  - A kiosk deasserts req on the edge where it samples ack.
  - req_prod and req_credit must be stable while req is high; they are only sampled in IDLE.
- Latency: a refusal is acked 2 cycles after req is sampled in IDLE. A vend with eng_ready=1 and eng_done the next cycle is acked at cycle 4.
- Restock (accepted in any state, including reset release cycle+1):
  - stock[restock_prod] = min(3, stock + restock_qty).
  - Same-cycle decrement of the same product: stock = min(3, stock - 1 + qty).
  - restock_prod of 0 or 3 is ignored.
- eng_done outside WAIT is ignored.
- Outputs other than ack, ack_status and ack_change are registered.

Test Plan:
1. Reset, then kiosk0 requests prod=1, credit=20; eng_ready=1, eng_done one cycle later -> ack=0001, status 00, change 5, stock1=2, eng_valid high exactly 1 cycle.
2. All four kiosks request simultaneously: prod 2, credit 20, each with an immediate engine handshake -> acks in order 0,1,2,3, every change 0. stock2 hits 0 after 3 vends, so kiosk3 gets status 10, change 20.
3. kiosk2 requests prod=2, credit=15 -> status 01, change 15, ack 2 cycles after grant, eng_valid never asserted, stock unchanged.
4. Engine eng_ready held 0 for 5 cycles then 1, eng_done never asserted -> eng_valid and eng_prod stable for all 6 cycles. Then TIMEOUT=15 cycles in WAIT -> status 11, change = full credit, stock decremented.
5. stock1=1: restock prod1 qty3 on the same edge as the ISSUE handshake for prod1 -> stock1=3. restock_prod=3 -> no change.
6. rst asserted during WAIT -> no ack, eng_valid=0, stocks=3, pointer=0. Next request from kiosk1 is served normally.
